// File: rtl/mem_bus_responder.sv
// Memory-bus responder: answers each request after a bounded wait and keeps a shadow of one tracked word.
// Optional protocol checker enabled by defining MEM_BUS_RESPONDER_PROTO_CHECK_EN.
module mem_bus_responder #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic [3:0]  any_delay,
  input  logic [31:0] any_rdata,
  input  logic [31:0] dmem_addr,
  output logic [31:0] dmem_data,
  output logic        err
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] dmem_q, dmem_d;
  logic        word_match;
  logic        is_read;
  logic        unused_bits;

  function automatic logic [3:0] sat_delay(input logic [3:0] d);
    return (d > MAX_WAIT_C) ? MAX_WAIT_C : d;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Match uses the live tracked address so it may move while a transfer waits.
  assign word_match = (addr_q[31:2] == dmem_addr[31:2]);
  assign is_read    = (wstrb_q == 4'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      instr_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      dmem_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      dmem_q  <= dmem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    dmem_d  = dmem_q;
    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          instr_d = mem_instr;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          cnt_d   = sat_delay(any_delay);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        state_d = IDLE;
        if (!is_read && word_match) dmem_d = merge_lanes(dmem_q, wdata_q, wstrb_q);
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_ready = (state_q == RESP);
  assign mem_rdata = (state_q != RESP)        ? 32'd0 :
                     (is_read && word_match)  ? dmem_q : any_rdata;
  assign dmem_data = dmem_q;

`ifdef MEM_BUS_RESPONDER_PROTO_CHECK_EN
  logic err_q, err_d;

  // Request must stay stable from acceptance until its response; fetches never write.
  always_comb begin
    err_d = err_q;
    if ((state_q == WAIT || state_q == RESP) &&
        (!mem_valid || mem_instr != instr_q || mem_addr != addr_q ||
         mem_wdata != wdata_q || mem_wstrb != wstrb_q))
      err_d = 1'b1;
    if (mem_valid && mem_instr && (mem_wstrb != 4'd0))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign unused_bits = ^{instr_q, addr_q[1:0], dmem_addr[1:0]};

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: stimulus pushes expected responses, a monitor checks each mem_ready pulse.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [3:0]  any_delay = '0;
  logic [31:0] any_rdata = '0;
  logic [31:0] dmem_addr = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] dmem_data;
  logic        err;

`ifdef MEM_BUS_RESPONDER_PROTO_CHECK_EN
  localparam logic [31:0] EXP_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_ERR = 32'd0;
`endif

  mem_bus_responder #(.MAX_WAIT(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .any_delay (any_delay),
    .any_rdata (any_rdata),
    .dmem_addr (dmem_addr),
    .dmem_data (dmem_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          issue;
    string       name;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response pops one expectation; outside responses rdata must be zero.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (mem_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ready: got response rdata %h expected no response", mem_rdata);
        end else begin
          e = sb.pop_front();
          check({e.name, " rdata"}, mem_rdata, e.rdata);
          check({e.name, " latency"}, 32'(cyc - e.issue), 32'(e.lat));
        end
      end else if (resetn === 1'b1) begin
        check("idle_rdata", mem_rdata, 32'd0);
      end
    end
  end

  // mid_sel: 0 none, 1 move dmem_addr during WAIT, 2 change mem_addr during WAIT
  task automatic do_req(input string name, input logic instr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb, input logic [3:0] delay,
                        input logic [31:0] rany, input logic [31:0] exp_rdata, input int exp_lat,
                        input int mid_sel, input logic [31:0] mid_val);
    exp_t e;
    bit   seen;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_instr = instr;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    any_delay = delay;
    any_rdata = rany;
    e.rdata = exp_rdata;
    e.lat   = exp_lat;
    e.issue = cyc;
    e.name  = name;
    sb.push_back(e);
    if (mid_sel != 0) begin
      @(negedge clk);
      if (mid_sel == 1) dmem_addr = mid_val;
      else              mem_addr  = mid_val;
    end
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      #2;
      if (mem_ready === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: got no mem_ready in 40 cycles expected latency %0d", name, exp_lat);
      sb.delete();
    end
    @(negedge clk);
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_wstrb = 4'd0;
  endtask

  initial begin
    #2 resetn = 1'b0;
    #1;
    check("reset ready", {31'd0, mem_ready}, 32'd0);
    check("reset rdata", mem_rdata, 32'd0);
    check("reset dmem", dmem_data, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    repeat (2) @(negedge clk);
    resetn    = 1'b1;
    dmem_addr = 32'h100;

    do_req("rd_shadow0",   1'b0, 32'h100, 32'h0,        4'h0, 4'd0,  32'hDEADBEEF, 32'h00000000, 2, 0, 32'h0);
    do_req("wr_0101",      1'b0, 32'h102, 32'h11223344, 4'h5, 4'd1,  32'h55AA55AA, 32'h55AA55AA, 3, 0, 32'h0);
    check("dmem after wr_0101", dmem_data, 32'h00220044);
    do_req("rd_after_wr",  1'b0, 32'h100, 32'h0,        4'h0, 4'd2,  32'h00000000, 32'h00220044, 4, 0, 32'h0);
    do_req("rd_untracked", 1'b0, 32'h200, 32'h0,        4'h0, 4'd9,  32'hCAFEF00D, 32'hCAFEF00D, 6, 0, 32'h0);
    do_req("rd_delay15",   1'b0, 32'h103, 32'h0,        4'h0, 4'd15, 32'h12345678, 32'h00220044, 6, 0, 32'h0);
    do_req("wr_1010",      1'b0, 32'h101, 32'hAABBCCDD, 4'hA, 4'd3,  32'h00000000, 32'h00000000, 5, 0, 32'h0);
    check("dmem after wr_1010", dmem_data, 32'hAA22CC44);
    do_req("wr_nomatch",   1'b0, 32'h104, 32'hFFFFFFFF, 4'hF, 4'd0,  32'h0BADF00D, 32'h0BADF00D, 2, 0, 32'h0);
    check("dmem after wr_nomatch", dmem_data, 32'hAA22CC44);
    do_req("ifetch",       1'b1, 32'h100, 32'h0,        4'h0, 4'd1,  32'h00000000, 32'hAA22CC44, 3, 0, 32'h0);
    do_req("dmem_move",    1'b0, 32'h300, 32'h0,        4'h0, 4'd3,  32'h77777777, 32'hAA22CC44, 5, 1, 32'h300);
    dmem_addr = 32'h100;
    check("err before violation", {31'd0, err}, 32'd0);

    do_req("addr_change",  1'b0, 32'h100, 32'h0,        4'h0, 4'd2,  32'h00000000, 32'hAA22CC44, 4, 2, 32'h104);
    check("err after addr change", {31'd0, err}, EXP_ERR);
    do_req("after_err",    1'b0, 32'h200, 32'h0,        4'h0, 4'd0,  32'h00000001, 32'h00000001, 2, 0, 32'h0);
    check("err sticky", {31'd0, err}, EXP_ERR);

    // Reset in the middle of a write's wait phase
    @(negedge clk);
    mem_valid = 1'b1;
    mem_instr = 1'b0;
    mem_addr  = 32'h100;
    mem_wdata = 32'hFFFFFFFF;
    mem_wstrb = 4'hF;
    any_delay = 4'd4;
    any_rdata = 32'h0;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midrst ready", {31'd0, mem_ready}, 32'd0);
    check("midrst dmem", dmem_data, 32'd0);
    check("midrst err", {31'd0, err}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("midrst hold ready", {31'd0, mem_ready}, 32'd0);
    end
    @(negedge clk);
    mem_valid = 1'b0;
    mem_wstrb = 4'd0;
    resetn    = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("postrst dmem", dmem_data, 32'd0);
    check("postrst ready", {31'd0, mem_ready}, 32'd0);
    do_req("rd_postrst",   1'b0, 32'h100, 32'h0,        4'h0, 4'd0,  32'hDEADBEEF, 32'h00000000, 2, 0, 32'h0);

    repeat (3) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4, giving the upper bound on inserted wait cycles per transfer (range 0-15).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mem_valid  input  1  core request valid.
REQ-005 SHALL have port mem_instr  input  1  request is an instruction fetch.
REQ-006 SHALL have port mem_addr  input  32  request byte address.
REQ-007 SHALL have port mem_wdata  input  32  write data.
REQ-008 SHALL have port mem_wstrb  input  4  byte write enables; 0 means read.
REQ-009 SHALL have port mem_ready  output  1  transfer completes this cycle.
REQ-010 SHALL have port mem_rdata  output  32  read data, valid while mem_ready=1.
REQ-011 SHALL have port any_delay  input  4  requested wait count, sampled at request acceptance.
REQ-012 SHALL have port any_rdata  input  32  unconstrained read data for untracked addresses.
REQ-013 SHALL have port dmem_addr  input  32  tracked word address.
REQ-014 SHALL have port dmem_data  output  32  shadow contents of the tracked word.
REQ-015 SHALL have port err  output  1  sticky bus-protocol violation flag.

Function
REQ-016 SHALL implement states IDLE, WAIT, RESP.
REQ-017 IDLE: when mem_valid=1, SHALL latch mem_instr/addr/wdata/wstrb, load cnt = min(any_delay, MAX_WAIT), and enter WAIT.
REQ-018 WAIT: when cnt=0, SHALL enter RESP; otherwise cnt decrements by 1.
REQ-019 RESP: mem_ready SHALL be 1 for exactly one cycle; next state SHALL be IDLE; mem_ready SHALL be 0 in all other states.
REQ-020 Latency: a request first seen at edge k SHALL see mem_ready=1 in the cycle after edge k+1+cnt; minimum gap between two mem_ready pulses is 2 cycles.
REQ-021 Word match SHALL compare latched addr[31:2] with live dmem_addr[31:2]; low address bits are ignored.
REQ-022 In RESP, mem_rdata SHALL be dmem_data on a read with word match, else any_rdata; outside RESP it SHALL be 0.
REQ-023 On the edge ending RESP, a write with word match SHALL update each dmem_data byte lane i for which wstrb[i]=1; other lanes hold.
REQ-024 A read and write in consecutive transfers to the tracked word SHALL return the written value (no bypass needed; the update precedes the next RESP).
REQ-025 Changing dmem_addr mid-transfer SHALL affect only the match evaluated in RESP.

Reset
REQ-026 resetn=0 SHALL immediately force state IDLE, cnt=0, mem_ready=0, mem_rdata=0, dmem_data=0, err=0, and latched request fields to 0, regardless of transfer in progress.
REQ-027 The first request SHALL be accepted no earlier than the first rising edge with resetn=1.

Configuration
REQ-028 Macro MEM_BUS_RESPONDER_PROTO_CHECK_EN defined: in WAIT or RESP, err SHALL set on mem_valid=0 or any of mem_instr/addr/wdata/wstrb differing from latched values; in any state, err SHALL set on mem_valid=1 with mem_instr=1 and mem_wstrb!=0; err holds until reset.
REQ-029 Macro undefined: err SHALL be constant 0 and no checker logic SHALL be present; all other behaviour is identical.

Verification
REQ-030 Read, dmem_addr=0x100, mem_addr=0x100, any_delay=0, any_rdata=0xDEADBEEF -> mem_ready 2 cycles after valid, mem_rdata=0x00000000 (shadow).
REQ-031 Write 0x11223344 wstrb=0b0101 to 0x102, then read 0x100 -> mem_rdata=0x00220044.
REQ-032 Read 0x200, any_delay=9, MAX_WAIT=4, any_rdata=0xCAFEF00D -> mem_ready exactly 6 cycles after valid, mem_rdata=0xCAFEF00D.
REQ-033 resetn pulsed low during WAIT after write 0xFFFFFFFF to tracked word -> mem_ready never asserted for that transfer, dmem_data=0, state IDLE.
REQ-034 With MEM_BUS_RESPONDER_PROTO_CHECK_EN, mem_addr changed from 0x100 to 0x104 during WAIT -> err=1 next cycle, stays 1 until resetn=0; without macro err=0.
